// File: rtl/control_multi.sv
// rtl/control_multi.sv - multi-cycle control FSM for riscy32_multi; optional JALR support under CONTROL_JALR_EN
module control_multi #(
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    input  logic [3:0]            flags,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  Illegal,
    output logic [3:0]            State,
    output logic [CNT_W-1:0]      InstRet
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_JALR     = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t     state;
    state_t     state_next;
    logic [3:0] alu_op;
    logic [3:0] alu_sel;
    logic       taken;
    logic       retire;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    assign State      = state;
    assign ALUControl = ALU_CTRL_W'(alu_sel);

    // Arithmetic op from funct3/funct7; funct7 selects SUB only for R-type, SRA for both R and I shifts
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'd0:    alu_op = (funct7 && state == S_EXECR) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_op = ALU_SLL;
            3'd2:    alu_op = ALU_SLT;
            3'd3:    alu_op = ALU_SLTU;
            3'd4:    alu_op = ALU_XOR;
            3'd5:    alu_op = funct7 ? ALU_SRA : ALU_SRL;
            3'd6:    alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    // Branch condition from the ALU compare flags of the current cycle
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'd0:    taken = flag_z;
            3'd1:    taken = !flag_z;
            3'd4:    taken = flag_n ^ flag_v;
            3'd5:    taken = !(flag_n ^ flag_v);
            3'd6:    taken = !flag_c;
            3'd7:    taken = flag_c;
            default: taken = 1'b0;
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:  ImmSrc = 3'b001;
            OP_BRANCH: ImmSrc = 3'b010;
            OP_JAL:    ImmSrc = 3'b011;
            OP_LUI:    ImmSrc = 3'b100;
            default:   ImmSrc = 3'b000;
        endcase
    end

    // Next state and per-state datapath controls; write enables are masked while reset is high
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_sel    = ALU_ADD;
        Illegal    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
`ifdef CONTROL_JALR_EN
                    OP_JALR:           state_next = S_JALR;
`endif
                    default: begin
                        state_next = S_FETCH;
                        Illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_sel    = alu_op;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_sel    = alu_op;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                alu_sel    = (funct3 == 3'd6 || funct3 == 3'd7) ? ALU_SLTU : ALU_SUB;
                PCWrite    = taken;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                state_next = S_ALUWB;
            end
`ifdef CONTROL_JALR_EN
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = S_JAL;
            end
`endif
            default: state_next = S_FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge clk) begin
        if (reset)       InstRet <= '0;
        else if (retire) InstRet <= InstRet + CNT_W'(1);
    end

endmodule
